gpu_instruction_fifo: RTL and testbench

- Buffers complete draw instructions produced by the GPU instruction decoder and presents them to the rasterizer/draw engine through a valid/ready handshake.
- Each accepted instruction is one entry containing the opcode, both endpoints, radius, octant mask and RGB colour.
- It absorbs bursts of draw commands while the draw engine is busy, and it reports full, empty, occupancy and sticky overflow.

---
 rtl/gpu_instruction_fifo_if.sv | 59 +++++
 rtl/gpu_instruction_fifo.sv | 112 +++++++++++
 tb/tb_gpu_instruction_fifo.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/gpu_instruction_fifo_if.sv
// Decoder/draw-engine bundle for the instruction FIFO: push side with field inputs,
// show-ahead head outputs, pop/ready and status flags.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

interface gpu_instruction_fifo_if #(
    parameter int unsigned PTR_BITS = 3
);
    logic                     push_i;
    logic [3:0]               opcode_i;
    logic [`WIDTH_BITS-1:0]   x1_i;
    logic [`HEIGHT_BITS-1:0]  y1_i;
    logic [`WIDTH_BITS-1:0]   x2_i;
    logic [`HEIGHT_BITS-1:0]  y2_i;
    logic [`WIDTH_BITS-1:0]   rad_i;
    logic [2:0]               oct_i;
    logic [`CHANNEL_BITS-1:0] r_i;
    logic [`CHANNEL_BITS-1:0] g_i;
    logic [`CHANNEL_BITS-1:0] b_i;
    logic                     pop_i;
    logic                     clear_overflow_i;

    logic                     valid_o;
    logic [3:0]               opcode_o;
    logic [`WIDTH_BITS-1:0]   x1_o;
    logic [`HEIGHT_BITS-1:0]  y1_o;
    logic [`WIDTH_BITS-1:0]   x2_o;
    logic [`HEIGHT_BITS-1:0]  y2_o;
    logic [`WIDTH_BITS-1:0]   rad_o;
    logic [2:0]               oct_o;
    logic [`CHANNEL_BITS-1:0] r_o;
    logic [`CHANNEL_BITS-1:0] g_o;
    logic [`CHANNEL_BITS-1:0] b_o;
    logic                     full_o;
    logic                     empty_o;
    logic [PTR_BITS:0]        count_o;
    logic                     overflow_o;

    modport slave (
        input  push_i, opcode_i, x1_i, y1_i, x2_i, y2_i, rad_i, oct_i, r_i, g_i, b_i,
        input  pop_i, clear_overflow_i,
        output valid_o, opcode_o, x1_o, y1_o, x2_o, y2_o, rad_o, oct_o, r_o, g_o, b_o,
        output full_o, empty_o, count_o, overflow_o
    );

    modport master (
        output push_i, opcode_i, x1_i, y1_i, x2_i, y2_i, rad_i, oct_i, r_i, g_i, b_i,
        output pop_i, clear_overflow_i,
        input  valid_o, opcode_o, x1_o, y1_o, x2_o, y2_o, rad_o, oct_o, r_o, g_o, b_o,
        input  full_o, empty_o, count_o, overflow_o
    );
endinterface

// File: rtl/gpu_instruction_fifo.sv
// Show-ahead FIFO of packed draw instructions between the GPU decoder and the draw engine,
// with full/empty/count status and a sticky overflow flag for dropped pushes.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_instruction_fifo #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned PTR_BITS = 3
) (
    input logic                   clk,
    input logic                   n_rst,
    gpu_instruction_fifo_if.slave bus
);
    typedef struct packed {
        logic [3:0]               opcode;
        logic [`WIDTH_BITS-1:0]   x1;
        logic [`HEIGHT_BITS-1:0]  y1;
        logic [`WIDTH_BITS-1:0]   x2;
        logic [`HEIGHT_BITS-1:0]  y2;
        logic [`WIDTH_BITS-1:0]   rad;
        logic [2:0]               oct;
        logic [`CHANNEL_BITS-1:0] r;
        logic [`CHANNEL_BITS-1:0] g;
        logic [`CHANNEL_BITS-1:0] b;
    } entry_t;

    localparam logic [PTR_BITS:0] FullCount = (PTR_BITS + 1)'(DEPTH);
    localparam logic [PTR_BITS-1:0] PtrOne  = PTR_BITS'(1);

    entry_t              mem_q [DEPTH];
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS:0]   count_q, count_d;
    logic                overflow_q, overflow_d;

    logic   full, empty, valid;
    logic   do_push, do_pop, drop;
    entry_t wr_entry, head;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);
    assign valid = ~empty;

    // A push into a full FIFO is only safe when the head leaves on the same edge.
    assign do_pop  = valid & bus.pop_i;
    assign do_push = bus.push_i & (~full | bus.pop_i);
    assign drop    = bus.push_i & full & ~bus.pop_i;

    assign wr_entry = '{opcode: bus.opcode_i, x1: bus.x1_i, y1: bus.y1_i, x2: bus.x2_i,
                        y2: bus.y2_i, rad: bus.rad_i, oct: bus.oct_i, r: bus.r_i,
                        g: bus.g_i, b: bus.b_i};

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_pop) rd_ptr_d = rd_ptr_q + PtrOne;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Set beats clear when both happen on the same edge.
        if (drop) overflow_d = 1'b1;
        else if (bus.clear_overflow_i) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head = valid ? mem_q[rd_ptr_q] : '0;

    assign bus.valid_o    = valid;
    assign bus.opcode_o   = head.opcode;
    assign bus.x1_o       = head.x1;
    assign bus.y1_o       = head.y1;
    assign bus.x2_o       = head.x2;
    assign bus.y2_o       = head.y2;
    assign bus.rad_o      = head.rad;
    assign bus.oct_o      = head.oct;
    assign bus.r_o        = head.r;
    assign bus.g_o        = head.g;
    assign bus.b_o        = head.b;
    assign bus.full_o     = full;
    assign bus.empty_o    = empty;
    assign bus.count_o    = count_q;
    assign bus.overflow_o = overflow_q;
endmodule

// File: tb/tb_gpu_instruction_fifo.sv
// Directed bench for gpu_instruction_fifo: reset, single entry, fill/overflow/clear,
// full push+pop, wrap-around ordering, empty push+pop and mid-operation reset.
module tb_gpu_instruction_fifo;
    logic clk;
    logic n_rst;
    int   n_tests;
    int   n_fail;

    gpu_instruction_fifo_if #(.PTR_BITS(3)) bus ();

    gpu_instruction_fifo #(
        .DEPTH   (8),
        .PTR_BITS(3)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input logic [3:0] op, input logic [9:0] x1, input logic [8:0] y1,
                             input logic [9:0] x2, input logic [8:0] y2, input logic [9:0] rad,
                             input logic [2:0] oct, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b);
        bus.opcode_i = op;
        bus.x1_i     = x1;
        bus.y1_i     = y1;
        bus.x2_i     = x2;
        bus.y2_i     = y2;
        bus.rad_i    = rad;
        bus.oct_i    = oct;
        bus.r_i      = r;
        bus.g_i      = g;
        bus.b_i      = b;
    endtask

    task automatic step(input logic push, input logic pop, input logic [3:0] op,
                        input logic [9:0] x1);
        set_entry(op, x1, 9'd0, 10'd0, 9'd0, 10'd0, 3'd0, 8'd0, 8'd0, 8'd0);
        bus.push_i = push;
        bus.pop_i  = pop;
        cycle();
        bus.push_i = 1'b0;
        bus.pop_i  = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        n_rst   = 1'b0;
        bus.push_i = 1'b0;
        bus.pop_i  = 1'b0;
        bus.clear_overflow_i = 1'b0;
        set_entry(4'd0, 10'd0, 9'd0, 10'd0, 9'd0, 10'd0, 3'd0, 8'd0, 8'd0, 8'd0);
        #12;
        check_eq("rst_valid", 32'(bus.valid_o), 32'd0);
        check_eq("rst_empty", 32'(bus.empty_o), 32'd1);
        check_eq("rst_full", 32'(bus.full_o), 32'd0);
        check_eq("rst_count", 32'(bus.count_o), 32'd0);
        check_eq("rst_ovf", 32'(bus.overflow_o), 32'd0);
        check_eq("rst_opcode", 32'(bus.opcode_o), 32'd0);
        n_rst = 1'b1;
        cycle();

        // Single push then pop
        set_entry(4'd4, 10'd10, 9'd20, 10'd30, 9'd40, 10'd0, 3'd0, 8'd1, 8'd2, 8'd3);
        bus.push_i = 1'b1;
        cycle();
        bus.push_i = 1'b0;
        check_eq("one_valid", 32'(bus.valid_o), 32'd1);
        check_eq("one_count", 32'(bus.count_o), 32'd1);
        check_eq("one_opcode", 32'(bus.opcode_o), 32'd4);
        check_eq("one_x1", 32'(bus.x1_o), 32'd10);
        check_eq("one_y1", 32'(bus.y1_o), 32'd20);
        check_eq("one_x2", 32'(bus.x2_o), 32'd30);
        check_eq("one_y2", 32'(bus.y2_o), 32'd40);
        check_eq("one_rad", 32'(bus.rad_o), 32'd0);
        check_eq("one_oct", 32'(bus.oct_o), 32'd0);
        check_eq("one_rgb", {8'd0, bus.r_o, bus.g_o, bus.b_o}, 32'h00010203);
        step(1'b0, 1'b1, 4'd0, 10'd0);
        check_eq("one_pop_valid", 32'(bus.valid_o), 32'd0);
        check_eq("one_pop_empty", 32'(bus.empty_o), 32'd1);

        // Bit-exact check with all-ones-ish pattern on every field
        set_entry(4'hF, 10'h3FF, 9'h1AB, 10'h155, 9'h0F0, 10'h2AA, 3'd5, 8'hA5, 8'h5A, 8'hFF);
        bus.push_i = 1'b1;
        cycle();
        bus.push_i = 1'b0;
        check_eq("pat_fields", {bus.opcode_o, bus.x1_o, bus.y1_o, bus.oct_o, bus.r_o[5:0]},
                 {4'hF, 10'h3FF, 9'h1AB, 3'd5, 6'h25});
        check_eq("pat_rest", {bus.x2_o, bus.y2_o, bus.g_o, bus.b_o[4:0]},
                 {10'h155, 9'h0F0, 8'h5A, 5'h1F});
        check_eq("pat_rad", 32'(bus.rad_o), 32'h2AA);
        step(1'b0, 1'b1, 4'd0, 10'd0);

        // Fill to 8, 9th push dropped
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, 4'(4 + (i % 4)), 10'(i));
            if (i == 7) begin
                check_eq("fill_full", 32'(bus.full_o), 32'd1);
                check_eq("fill_count", 32'(bus.count_o), 32'd8);
                check_eq("fill_ovf_pre", 32'(bus.overflow_o), 32'd0);
            end
        end
        check_eq("ovf_set", 32'(bus.overflow_o), 32'd1);
        check_eq("ovf_count", 32'(bus.count_o), 32'd8);
        check_eq("ovf_head_op", 32'(bus.opcode_o), 32'd4);
        check_eq("ovf_head_x1", 32'(bus.x1_o), 32'd0);
        // Drop and clear on the same edge: set wins
        bus.clear_overflow_i = 1'b1;
        step(1'b1, 1'b0, 4'd9, 10'd500);
        check_eq("ovf_set_wins", 32'(bus.overflow_o), 32'd1);
        cycle();
        bus.clear_overflow_i = 1'b0;
        check_eq("ovf_clear", 32'(bus.overflow_o), 32'd0);

        // Full with push and pop together
        step(1'b1, 1'b1, 4'd6, 10'd99);
        check_eq("fpp_count", 32'(bus.count_o), 32'd8);
        check_eq("fpp_ovf", 32'(bus.overflow_o), 32'd0);
        check_eq("fpp_head_op", 32'(bus.opcode_o), 32'd5);
        check_eq("fpp_head_x1", 32'(bus.x1_o), 32'd1);
        for (int k = 0; k < 7; k++) begin
            check_eq("drain_x1", 32'(bus.x1_o), 32'(k + 1));
            step(1'b0, 1'b1, 4'd0, 10'd0);
        end
        check_eq("fpp_last_op", 32'(bus.opcode_o), 32'd6);
        check_eq("fpp_last_x1", 32'(bus.x1_o), 32'd99);
        step(1'b0, 1'b1, 4'd0, 10'd0);
        check_eq("drain_empty", 32'(bus.empty_o), 32'd1);
        // Pop while empty is ignored
        step(1'b0, 1'b1, 4'd0, 10'd0);
        check_eq("empty_pop_count", 32'(bus.count_o), 32'd0);
        check_eq("empty_pop_ovf", 32'(bus.overflow_o), 32'd0);

        // Wrap-around: 20 entries, occupancy kept within 1..3
        begin
            int exp_x1;
            exp_x1 = 0;
            step(1'b1, 1'b0, 4'd1, 10'd0);
            step(1'b1, 1'b0, 4'd1, 10'd1);
            for (int i = 2; i < 20; i++) begin
                check_eq("wrap_x1", 32'(bus.x1_o), 32'(exp_x1));
                check_eq("wrap_count", 32'(bus.count_o), 32'd2);
                step(1'b1, 1'b1, 4'd1, 10'(i));
                exp_x1++;
            end
            for (int i = 0; i < 2; i++) begin
                check_eq("wrap_tail_x1", 32'(bus.x1_o), 32'(exp_x1));
                step(1'b0, 1'b1, 4'd0, 10'd0);
                exp_x1++;
            end
            check_eq("wrap_total", 32'(exp_x1), 32'd20);
            check_eq("wrap_empty", 32'(bus.empty_o), 32'd1);
        end

        // Empty with push and pop together
        step(1'b1, 1'b1, 4'd3, 10'd77);
        check_eq("epp_count", 32'(bus.count_o), 32'd1);
        check_eq("epp_op", 32'(bus.opcode_o), 32'd3);
        check_eq("epp_x1", 32'(bus.x1_o), 32'd77);
        step(1'b0, 1'b1, 4'd0, 10'd0);

        // Reset mid-operation after 3 pushes
        step(1'b1, 1'b0, 4'd7, 10'd1);
        step(1'b1, 1'b0, 4'd7, 10'd2);
        step(1'b1, 1'b0, 4'd7, 10'd3);
        check_eq("mid_pre_count", 32'(bus.count_o), 32'd3);
        #2;
        n_rst = 1'b0;
        #1;
        check_eq("mid_valid", 32'(bus.valid_o), 32'd0);
        check_eq("mid_count", 32'(bus.count_o), 32'd0);
        check_eq("mid_empty", 32'(bus.empty_o), 32'd1);
        check_eq("mid_opcode", 32'(bus.opcode_o), 32'd0);
        n_rst = 1'b1;
        cycle();
        step(1'b1, 1'b0, 4'd2, 10'd321);
        check_eq("post_rst_count", 32'(bus.count_o), 32'd1);
        check_eq("post_rst_op", 32'(bus.opcode_o), 32'd2);
        check_eq("post_rst_x1", 32'(bus.x1_o), 32'd321);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
